mux8to1_sel_sequencer: RTL and testbench

//   Upstream driver for the 8:1 registered mux stage. Takes 8-bit words over a valid/ready handshake.

---
 rtl/mux8to1_sel_sequencer.sv | 138 +++++++++++++
 tb/tb_mux8to1_sel_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux8to1_sel_sequencer.sv
// mux8to1_sel_sequencer
//   Feeds an 8:1 registered mux. Accepts 8-bit words over a valid/ready handshake, holds each
//   word on data_out and steps selection_out through all 8 positions (one per clock), so the
//   mux serialises the word. The bit_valid/frame markers are delayed one clock to line up with
//   the mux's registered output.
//
// Parameters
//   MSB_FIRST   0: selection order 0..7, 1: order 7..0
//   GAP_CYCLES  forced idle cycles after each frame before the next accept (0..15)
//
// Ports
//   clk              clock, all state updates on posedge
//   rst              asynchronous active-high reset
//   word_in          word to serialise, sampled on accept
//   word_valid_in    upstream has a word on word_in
//   word_ready_out   block can accept word_in this cycle
//   data_out         to mux data input, stable for the whole frame
//   selection_out    to mux selection input
//   bit_valid_out    mux output this cycle is a valid serial bit
//   frame_start_out  mux output this cycle is bit 0 of a frame
//   frame_end_out    mux output this cycle is bit 7 of a frame
//   busy_out         sequencer is not idle

module mux8to1_sel_sequencer #(
    parameter int unsigned MSB_FIRST  = 0,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] word_in,
    input  logic       word_valid_in,
    output logic       word_ready_out,
    output logic [7:0] data_out,
    output logic [2:0] selection_out,
    output logic       bit_valid_out,
    output logic       frame_start_out,
    output logic       frame_end_out,
    output logic       busy_out
);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_t;

    localparam logic [2:0] FirstSel = (MSB_FIRST != 0) ? 3'd7 : 3'd0;
    localparam logic [3:0] GapLoad  = 4'(GAP_CYCLES);

    state_t     state_q, state_d;
    logic [2:0] count_q, count_d;
    logic [7:0] data_q, data_d;
    logic [2:0] sel_q, sel_d;
    logic [3:0] gap_q, gap_d;
    logic       ready;
    logic       accept;
    logic       shifting;

    // Mux position driven while the frame counter is at c.
    function automatic logic [2:0] sel_of(input logic [2:0] c);
        return (MSB_FIRST != 0) ? (3'd7 - c) : c;
    endfunction

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        sel_d   = sel_q;
        gap_d   = gap_q;
        ready   = 1'b0;

        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
            end
            StShift: begin
                if (count_q == 3'd7) begin
                    if (GAP_CYCLES == 0) begin
                        // Last bit: a waiting word follows with no bubble.
                        ready   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StGap;
                        gap_d   = GapLoad;
                    end
                end else begin
                    count_d = count_q + 3'd1;
                    sel_d   = sel_of(count_q + 3'd1);
                end
            end
            StGap: begin
                if (gap_q <= 4'd1) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        accept = ready & word_valid_in;
        if (accept) begin
            state_d = StShift;
            count_d = 3'd0;
            data_d  = word_in;
            sel_d   = FirstSel;
        end
    end

    assign shifting = (state_q == StShift);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            count_q         <= 3'd0;
            data_q          <= 8'd0;
            sel_q           <= 3'd0;
            gap_q           <= 4'd0;
            bit_valid_out   <= 1'b0;
            frame_start_out <= 1'b0;
            frame_end_out   <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            data_q          <= data_d;
            sel_q           <= sel_d;
            gap_q           <= gap_d;
            // Markers trail the selection by one clock, matching the mux output register.
            bit_valid_out   <= shifting;
            frame_start_out <= shifting && (count_q == 3'd0);
            frame_end_out   <= shifting && (count_q == 3'd7);
        end
    end

    assign word_ready_out = ready & ~rst;
    assign data_out       = data_q;
    assign selection_out  = sel_q;
    assign busy_out       = (state_q != StIdle);

endmodule

// File: tb/tb_mux8to1_sel_sequencer.sv
// Bench: two instances (A: LSB-first, no gap; B: MSB-first, GAP_CYCLES=2) each feeding a
// registered mux model. Accepted words push their expected serial bits into a per-instance
// queue; a monitor pops one entry per valid bit and checks bit value, frame markers and the
// idle bubble between back-to-back frames.

module tb_mux8to1_sel_sequencer;

    localparam int MSB[2] = '{0, 1};
    localparam int GAP[2] = '{0, 2};

    typedef struct packed {
        logic       b;
        logic       fs;
        logic       fe;
        logic       chk_gap;
        logic [7:0] gap;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] word_in     [2];
    logic       word_valid  [2];
    logic       word_ready  [2];
    logic [7:0] data_out    [2];
    logic [2:0] sel_out     [2];
    logic       bit_valid   [2];
    logic       frame_start [2];
    logic       frame_end   [2];
    logic       busy        [2];
    logic       mux_out     [2];

    exp_t exp_q [2][$];
    int   idle_cnt [2];
    bit   seen_end [2];

    int errors = 0;
    int checks = 0;

    mux8to1_sel_sequencer #(.MSB_FIRST(0), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .rst(rst), .word_in(word_in[0]), .word_valid_in(word_valid[0]),
        .word_ready_out(word_ready[0]), .data_out(data_out[0]), .selection_out(sel_out[0]),
        .bit_valid_out(bit_valid[0]), .frame_start_out(frame_start[0]),
        .frame_end_out(frame_end[0]), .busy_out(busy[0])
    );

    mux8to1_sel_sequencer #(.MSB_FIRST(1), .GAP_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst), .word_in(word_in[1]), .word_valid_in(word_valid[1]),
        .word_ready_out(word_ready[1]), .data_out(data_out[1]), .selection_out(sel_out[1]),
        .bit_valid_out(bit_valid[1]), .frame_start_out(frame_start[1]),
        .frame_end_out(frame_end[1]), .busy_out(busy[1])
    );

    // Downstream registered 8:1 mux.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) mux_out[i] <= data_out[i][sel_out[i]];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called just after a posedge. Presents w, waits for ready, records the expected bits and
    // returns just after the accept edge with valid still asserted.
    task automatic send(input int i, input logic [7:0] w, input bit chain);
        int   n;
        bit   ok;
        exp_t e;
        word_in[i]    = w;
        word_valid[i] = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 64) begin
            @(negedge clk);
            if (word_ready[i]) ok = 1'b1;
            n++;
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            word_valid[i] = 1'b0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                e.b       = (MSB[i] != 0) ? w[7-k] : w[k];
                e.fs      = (k == 0);
                e.fe      = (k == 7);
                e.chk_gap = chain && (k == 0);
                e.gap     = (GAP[i] == 0) ? 8'd0 : 8'(GAP[i] + 1);
                exp_q[i].push_back(e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int i, input int n);
        word_valid[i] = 1'b0;
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: one expected entry per cycle the mux output is flagged.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    seen_end[i] = 1'b0;
                    idle_cnt[i] = 0;
                end else if (bit_valid[i] || frame_start[i] || frame_end[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check("unexpected_bit", {31'd0, bit_valid[i]}, 32'd0);
                    end else begin
                        e = exp_q[i].pop_front();
                        check("bit_valid", {31'd0, bit_valid[i]}, 32'd1);
                        check("serial_bit", {31'd0, mux_out[i]}, {31'd0, e.b});
                        check("frame_start", {31'd0, frame_start[i]}, {31'd0, e.fs});
                        check("frame_end", {31'd0, frame_end[i]}, {31'd0, e.fe});
                        if (e.fs && e.chk_gap && seen_end[i])
                            check("frame_bubble", idle_cnt[i], {24'd0, e.gap});
                    end
                    if (frame_end[i]) begin
                        seen_end[i] = 1'b1;
                        idle_cnt[i] = 0;
                    end
                end else if (seen_end[i]) begin
                    idle_cnt[i]++;
                end
            end
        end
    end

    initial begin
        int  n;
        bit  hold;
        for (int i = 0; i < 2; i++) begin
            word_in[i]    = 8'd0;
            word_valid[i] = 1'b0;
        end
        rst = 1'b1;

        // Reset state
        #12;
        for (int i = 0; i < 2; i++) begin
            check("rst_outputs", {data_out[i], sel_out[i], bit_valid[i], frame_start[i],
                                  frame_end[i], busy[i], word_ready[i]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("post_rst_ready", {31'd0, word_ready[i]}, 32'd1);
            check("post_rst_busy", {30'd0, busy[i], bit_valid[i]}, 32'd0);
        end

        // A: single word, then back-to-back pair
        send(0, 8'b1011_0010, 1'b0);
        check("busy_in_frame", {31'd0, busy[0]}, 32'd1);
        idle(0, 12);
        send(0, 8'hA5, 1'b0);
        send(0, 8'h3C, 1'b1);
        idle(0, 12);

        // B: MSB-first single word, then held-valid chain through the gap
        send(1, 8'h80, 1'b0);
        idle(1, 14);
        send(1, 8'h96, 1'b0);
        send(1, 8'h4B, 1'b1);
        send(1, 8'hE1, 1'b1);
        idle(1, 16);

        // Randomised words, holds and idle spacing
        for (int i = 0; i < 2; i++) begin
            hold = 1'b0;
            for (int k = 0; k < 15; k++) begin
                send(i, 8'($urandom), hold);
                hold = 1'($urandom_range(0, 1));
                if (!hold) idle(i, $urandom_range(0, 5));
            end
            idle(i, 20);
        end

        // Async reset in the middle of an A frame (count 4), off the clock edge
        send(0, 8'h5A, 1'b0);
        word_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_bit_valid", {31'd0, bit_valid[0]}, 32'd0);
        check("midrst_busy", {31'd0, busy[0]}, 32'd0);
        check("midrst_frame_end", {31'd0, frame_end[0]}, 32'd0);
        check("midrst_ready", {31'd0, word_ready[0]}, 32'd0);
        for (int i = 0; i < 2; i++) exp_q[i].delete();
        #9;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after_rst_busy", {30'd0, busy[0], bit_valid[0]}, 32'd0);
        send(0, 8'hFF, 1'b0);
        check("after_rst_sel", {29'd0, sel_out[0]}, 32'd0);
        idle(0, 12);

        // Every expected bit must have come out
        n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        check("drain_a", exp_q[0].size(), 32'd0);
        check("drain_b", exp_q[1].size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
